// File: rtl/snes_usb_pkg.sv
// Shared types and constants for the SNES B-bus to FT245 USB FIFO bridge.
package snes_usb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdPulse,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StRecover
  } usb_state_e;

  localparam logic [7:0] ADDR_STATUS = 8'hFE;
  localparam logic [7:0] ADDR_DATA   = 8'hFF;

  localparam int unsigned RXV = 7;
  localparam int unsigned TXR = 6;
  localparam int unsigned ONE = 5;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/snes_strobe_sync.sv
// Synchronizes the B-bus read/write strobes, keeps addr/data aligned with them,
// and produces single-cycle rising-edge pulses. Requires STAGES >= 2.
module snes_strobe_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       rd_rise,
  output logic       wr_rise,
  output logic [7:0] addr_sync,
  output logic [7:0] data_sync
);

  logic [STAGES-1:0]      rd_q, wr_q;
  logic                   rd_prev_q, wr_prev_q;
  logic [STAGES-1:0][7:0] addr_q, data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '1;
      wr_q      <= '1;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      rd_q      <= {rd_q[STAGES-2:0], rd_n};
      wr_q      <= {wr_q[STAGES-2:0], wr_n};
      addr_q    <= {addr_q[STAGES-2:0], addr};
      data_q    <= {data_q[STAGES-2:0], data};
      rd_prev_q <= rd_q[STAGES-1];
      wr_prev_q <= wr_q[STAGES-1];
    end
  end

  assign rd_rise   = rd_q[STAGES-1] & ~rd_prev_q;
  assign wr_rise   = wr_q[STAGES-1] & ~wr_prev_q;
  assign addr_sync = addr_q[STAGES-1];
  assign data_sync = data_q[STAGES-1];

endmodule

// File: rtl/snes_usb_bridge.sv
// SNES $21FE/$21FF to FT245 USB FIFO bridge with one-byte RX and TX buffers
// and full ownership of the FT245 strobe timing.
module snes_usb_bridge
  import snes_usb_pkg::*;
#(
  parameter int unsigned RD_PULSE    = 3,
  parameter int unsigned WR_PULSE    = 2,
  parameter int unsigned RECOVER     = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic [7:0] snes_d_in,
  output logic [7:0] snes_d_out,
  output logic       snes_d_oe,
  input  logic       PARD_n,
  input  logic       PAWR_n,
  input  logic       usb_en,
  input  logic       usb_rxf_n,
  input  logic       usb_txe_n,
  output logic       usb_rd_n,
  output logic       usb_wr_n,
  input  logic [7:0] usb_d_in,
  output logic [7:0] usb_d_out,
  output logic       usb_d_oe,
  output logic       tx_overflow
);

  localparam int unsigned MaxCnt = max3(RD_PULSE, WR_PULSE, RECOVER);
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  usb_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              rx_valid_q, tx_full_q;
  logic [7:0]        rx_data_q, tx_data_q;
  logic [SYNC_STAGES-1:0] rxf_sync_q, txe_sync_q;
  logic              rd_rise, wr_rise;
  logic [7:0]        addr_s, data_s;
  logic              tx_ready;
  logic [7:0]        status;

  snes_strobe_sync #(
    .STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_n     (PARD_n),
    .wr_n     (PAWR_n),
    .addr     (addr),
    .data     (snes_d_in),
    .rd_rise  (rd_rise),
    .wr_rise  (wr_rise),
    .addr_sync(addr_s),
    .data_sync(data_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxf_sync_q <= '1;
      txe_sync_q <= '1;
    end else begin
      rxf_sync_q <= {rxf_sync_q[SYNC_STAGES-2:0], usb_rxf_n};
      txe_sync_q <= {txe_sync_q[SYNC_STAGES-2:0], usb_txe_n};
    end
  end

  // SNES read path is combinational from the raw pins so the data is valid within the strobe.
  always_comb begin
    tx_ready   = ~tx_full_q & usb_en;
    status     = '0;
    snes_d_oe  = 1'b0;
    snes_d_out = '0;
    if (usb_en) begin
      status[RXV] = rx_valid_q;
      status[TXR] = tx_ready;
      status[ONE] = 1'b1;
    end
    if (!PARD_n && addr == ADDR_STATUS) begin
      snes_d_oe  = 1'b1;
      snes_d_out = status;
    end else if (!PARD_n && addr == ADDR_DATA) begin
      snes_d_oe  = 1'b1;
      snes_d_out = rx_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_valid_q  <= 1'b0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      tx_data_q   <= '0;
      tx_overflow <= 1'b0;
      usb_rd_n    <= 1'b1;
      usb_wr_n    <= 1'b1;
      usb_d_oe    <= 1'b0;
      usb_d_out   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (usb_en) begin
            if (tx_full_q && !txe_sync_q[SYNC_STAGES-1]) begin
              state_q   <= StWrSetup;
              usb_d_oe  <= 1'b1;
              usb_d_out <= tx_data_q;
            end else if (!rx_valid_q && !rxf_sync_q[SYNC_STAGES-1]) begin
              state_q  <= StRdPulse;
              usb_rd_n <= 1'b0;
              cnt_q    <= CntW'(RD_PULSE - 1);
            end
          end
        end
        StRdPulse: begin
          if (cnt_q == '0) begin
            rx_data_q  <= usb_d_in;
            rx_valid_q <= 1'b1;
            usb_rd_n   <= 1'b1;
            state_q    <= StRecover;
            cnt_q      <= CntW'(RECOVER - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrSetup: begin
          usb_wr_n <= 1'b0;
          state_q  <= StWrPulse;
          cnt_q    <= CntW'(WR_PULSE - 1);
        end
        StWrPulse: begin
          if (cnt_q == '0) begin
            usb_wr_n <= 1'b1;
            state_q  <= StWrHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrHold: begin
          tx_full_q <= 1'b0;
          usb_d_oe  <= 1'b0;
          state_q   <= StRecover;
          cnt_q     <= CntW'(RECOVER - 1);
        end
        StRecover: begin
          if (cnt_q == '0) state_q <= StIdle;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase

      // SNES-side updates come last so a push in WR_HOLD overrides the clear.
      if (rd_rise && addr_s == ADDR_DATA && rx_valid_q) rx_valid_q <= 1'b0;
      if (rd_rise && addr_s == ADDR_STATUS) tx_overflow <= 1'b0;
      if (wr_rise && addr_s == ADDR_DATA) begin
        if (!tx_full_q || state_q == StWrHold) begin
          tx_data_q <= data_s;
          tx_full_q <= 1'b1;
        end else begin
          tx_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snes_usb_bridge.sv
// Bench for snes_usb_bridge: read-path vector table, directed FT245 sequences,
// and a randomized SNES/host traffic run against a byte-stream reference model.
module tb_snes_usb_bridge;

  localparam int RdPulse = 3;
  localparam int WrPulse = 2;
  localparam int OeWidth = WrPulse + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] snes_d_in = 8'h00;
  logic [7:0] snes_d_out;
  logic       snes_d_oe;
  logic       PARD_n = 1'b1;
  logic       PAWR_n = 1'b1;
  logic       usb_en = 1'b1;
  logic       usb_rxf_n = 1'b1;
  logic       usb_txe_n = 1'b1;
  logic       usb_rd_n, usb_wr_n;
  logic [7:0] usb_d_in = 8'h00;
  logic [7:0] usb_d_out;
  logic       usb_d_oe;
  logic       tx_overflow;

  snes_usb_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .snes_d_in  (snes_d_in),
    .snes_d_out (snes_d_out),
    .snes_d_oe  (snes_d_oe),
    .PARD_n     (PARD_n),
    .PAWR_n     (PAWR_n),
    .usb_en     (usb_en),
    .usb_rxf_n  (usb_rxf_n),
    .usb_txe_n  (usb_txe_n),
    .usb_rd_n   (usb_rd_n),
    .usb_wr_n   (usb_wr_n),
    .usb_d_in   (usb_d_in),
    .usb_d_out  (usb_d_out),
    .usb_d_oe   (usb_d_oe),
    .tx_overflow(tx_overflow)
  );

  always #12 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FT245 device model and pin-level timing monitor, sampled on the falling edge.
  logic [7:0] host_q[$];
  logic [7:0] sent_q[$];
  int cyc = 0, rd_len = 0, wr_len = 0, oe_len = 0, rd_taken = 0;
  int rd_falls = 0, wr_falls = 0, overlap = 0;
  int oe_fall_cyc = 0, rd_fall_cyc = 0, wr_fall_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!usb_rd_n && !usb_wr_n) overlap++;
    if (usb_d_oe && !usb_rd_n) overlap++;
    if (usb_d_oe) oe_len++;
    else if (oe_len > 0) begin
      if (rst_n) checkn("oe_width", oe_len, OeWidth);
      oe_len = 0;
      oe_fall_cyc = cyc;
    end
    if (!usb_wr_n) begin
      wr_len++;
      if (wr_len == 1) begin
        wr_falls++;
        wr_fall_cyc = cyc;
        checkn("wr_after_oe", oe_len, 2);
      end
    end else if (wr_len > 0) begin
      if (rst_n) checkn("wr_width", wr_len, WrPulse);
      sent_q.push_back(usb_d_out);
      wr_len = 0;
    end
    if (!usb_rd_n) begin
      rd_len++;
      if (rd_len == 1) begin
        rd_falls++;
        rd_fall_cyc = cyc;
      end
    end else if (rd_len > 0) begin
      if (rst_n) checkn("rd_width", rd_len, RdPulse);
      rd_taken++;
      rd_len = 0;
    end
    usb_rxf_n = !(host_q.size() > rd_taken);
    usb_d_in  = (host_q.size() > rd_taken) ? host_q[rd_taken] : 8'h00;
  end

  task automatic snes_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(posedge clk); #1 addr = a; PARD_n = 1'b0;
    @(negedge clk); @(negedge clk);
    d  = snes_d_out;
    oe = snes_d_oe;
    @(posedge clk); #1 PARD_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 addr = 8'h00;
  endtask

  task automatic snes_write(input logic [7:0] a, input logic [7:0] v);
    @(posedge clk); #1 addr = a; snes_d_in = v; PAWR_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 PAWR_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 addr = 8'h00;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       oe;
    snes_read(a, d, oe);
    check1({name, "_oe"}, oe, 1'b1);
    check8(name, d, exp);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic       pard_n;
    logic [7:0] a;
    logic       exp_oe;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[7];

  logic [7:0] m_rx[$];
  logic [7:0] exp_sent[$];
  logic       m_txfull, m_ovf;
  logic [7:0] m_last, m_txb, rd_d, rnd;
  logic       rd_oe;
  int         sent_base, n_rd, n_wr, op, bound;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'hFE, 1'b1, 8'h60};
    vecs[1] = '{1'b0, 1'b0, 8'hFE, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'hFF, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 8'hFE, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'hFD, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'h7F, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 8'hFF, 1'b1, 8'h00};

    settle(3);
    check1("rst_rd_n", usb_rd_n, 1'b1);
    check1("rst_wr_n", usb_wr_n, 1'b1);
    check1("rst_oe", usb_d_oe, 1'b0);
    check8("rst_dout", usb_d_out, 8'h00);
    check1("rst_ovf", tx_overflow, 1'b0);
    rst_n = 1'b1;
    settle(4);

    // Combinational read path from reset state.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 usb_en = vecs[i].en; addr = vecs[i].a; PARD_n = vecs[i].pard_n;
      @(negedge clk);
      check1($sformatf("vec%0d_oe", i), snes_d_oe, vecs[i].exp_oe);
      if (vecs[i].exp_oe) check8($sformatf("vec%0d_d", i), snes_d_out, vecs[i].exp_d);
      @(posedge clk); #1 PARD_n = 1'b1; usb_en = 1'b1;
      settle(4);
    end

    // Reset asserted in the middle of an FT245 read pulse.
    host_q.push_back(8'h77);
    bound = 0;
    while (usb_rd_n && bound < 40) begin
      @(negedge clk);
      bound++;
    end
    check1("rd_start_seen", usb_rd_n, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check1("midrst_rd_n", usb_rd_n, 1'b1);
    check1("midrst_wr_n", usb_wr_n, 1'b1);
    check1("midrst_oe", usb_d_oe, 1'b0);
    settle(3);
    rst_n = 1'b1;
    settle(6);
    check1("post_rst_rd_n", usb_rd_n, 1'b1);
    check1("post_rst_oe", usb_d_oe, 1'b0);
    check8("post_rst_dout", usb_d_out, 8'h00);
    read_check("post_rst_status", 8'hFE, 8'h60);
    read_check("post_rst_data", 8'hFF, 8'h00);

    // Host sends $A5.
    host_q.push_back(8'hA5);
    settle(24);
    read_check("rx_status_full", 8'hFE, 8'hE0);
    read_check("rx_data", 8'hFF, 8'hA5);
    settle(8);
    read_check("rx_status_empty", 8'hFE, 8'h60);

    // SNES sends $3C with the FT245 ready.
    usb_txe_n = 1'b0;
    n_wr = sent_q.size();
    snes_write(8'hFF, 8'h3C);
    settle(24);
    checkn("tx_count", sent_q.size() - n_wr, 1);
    if (sent_q.size() > n_wr) check8("tx_byte", sent_q[n_wr], 8'h3C);
    read_check("tx_status", 8'hFE, 8'h60);

    // FT245 full: second write is dropped.
    usb_txe_n = 1'b1;
    n_wr = sent_q.size();
    snes_write(8'hFF, 8'h11);
    snes_write(8'hFF, 8'h22);
    settle(12);
    check1("ovf_set", tx_overflow, 1'b1);
    usb_txe_n = 1'b0;
    settle(24);
    checkn("ovf_tx_count", sent_q.size() - n_wr, 1);
    if (sent_q.size() > n_wr) check8("ovf_tx_byte", sent_q[n_wr], 8'h11);
    check1("ovf_kept", tx_overflow, 1'b1);
    read_check("ovf_status", 8'hFE, 8'h60);
    settle(6);
    check1("ovf_cleared", tx_overflow, 1'b0);

    // Link disabled with both directions pending, then enabled.
    usb_en = 1'b0;
    n_rd = rd_falls;
    n_wr = wr_falls;
    snes_write(8'hFF, 8'hAB);
    host_q.push_back(8'h5A);
    settle(24);
    checkn("dis_no_rd", rd_falls - n_rd, 0);
    checkn("dis_no_wr", wr_falls - n_wr, 0);
    read_check("dis_status", 8'hFE, 8'h00);
    n_wr = sent_q.size();
    usb_en = 1'b1;
    settle(30);
    checkn("en_rd", rd_falls - n_rd, 1);
    checkn("en_wr", wr_falls - n_wr, 1);
    check1("tx_before_rx", rd_fall_cyc > wr_fall_cyc, 1'b1);
    checkn("recover_gap", rd_fall_cyc - oe_fall_cyc, 3);
    if (sent_q.size() > n_wr) check8("en_tx_byte", sent_q[n_wr], 8'hAB);
    read_check("en_rx_data", 8'hFF, 8'h5A);
    settle(8);

    // Randomized traffic against a byte-stream model of both directions.
    m_txfull  = 1'b0;
    m_ovf     = 1'b0;
    m_last    = 8'h5A;
    m_txb     = 8'h00;
    sent_base = sent_q.size();
    for (int k = 0; k < 80; k++) begin
      op  = int'($urandom_range(0, 4));
      rnd = 8'($urandom);
      case (op)
        0: begin
          host_q.push_back(rnd);
          m_rx.push_back(rnd);
        end
        1: begin
          snes_read(8'hFE, rd_d, rd_oe);
          check8("rand_status", rd_d, {m_rx.size() > 0, !m_txfull, 1'b1, 5'b0});
          m_ovf = 1'b0;
        end
        2: begin
          snes_read(8'hFF, rd_d, rd_oe);
          if (m_rx.size() > 0) m_last = m_rx.pop_front();
          check8("rand_data", rd_d, m_last);
        end
        3: begin
          snes_write(8'hFF, rnd);
          if (m_txfull) m_ovf = 1'b1;
          else if (!usb_txe_n) exp_sent.push_back(rnd);
          else begin
            m_txfull = 1'b1;
            m_txb    = rnd;
          end
        end
        default: begin
          if (usb_txe_n && m_txfull) begin
            exp_sent.push_back(m_txb);
            m_txfull = 1'b0;
          end
          usb_txe_n = !usb_txe_n;
        end
      endcase
      settle(24);
      check1("rand_ovf", tx_overflow, m_ovf);
    end
    checkn("rand_sent_count", sent_q.size() - sent_base, exp_sent.size());
    for (int j = 0; j < exp_sent.size() && sent_base + j < sent_q.size(); j++)
      check8("rand_sent_byte", sent_q[sent_base + j], exp_sent[j]);
    checkn("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
